// File: rtl/uart_rx_fifo_if.sv
// Byte-stream interface between uart_rx and its receive FIFO, plus the FIFO's
// valid/ready read port. The slave modport is the FIFO side.
interface uart_rx_fifo_if;
  logic [7:0] uart_rx_data;
  logic       uart_valid;
  logic       uart_err;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_err;
  logic       fifo_rd_valid;
  logic       fifo_rd_ready;

  modport slave (
    input  uart_rx_data, uart_valid, uart_err, fifo_rd_ready,
    output fifo_rd_data, fifo_rd_err, fifo_rd_valid
  );

  modport master (
    output uart_rx_data, uart_valid, uart_err, fifo_rd_ready,
    input  fifo_rd_data, fifo_rd_err, fifo_rd_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: first-word-fall-through head, occupancy status, sticky overflow.
// Optional macro UART_RX_FIFO_ERR_DROP_EN drops framing-error bytes and counts them.
module uart_rx_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_rx_fifo_if.slave            bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     fifo_almost_full,
  output logic                     fifo_overflow,
  input  logic                     overflow_clr,
  output logic [7:0]               err_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = 9;  // {err, data}

  logic [WW-1:0] mem_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic [WW-1:0] head_q, head_d;
  logic [WW-1:0] wr_word_d;

  logic push_c;
  logic pop_c;
  logic drop_err_c;
  logic ovf_set_c;

  // Accept/drop decision; a pop in the same cycle frees the slot a full FIFO needs.
  always_comb begin
    pop_c      = rd_valid_q & bus.fifo_rd_ready;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    drop_err_c = bus.uart_valid & bus.uart_err;
`else
    drop_err_c = 1'b0;
`endif
    push_c     = bus.uart_valid & ~drop_err_c & (~full_q | pop_c);
    ovf_set_c  = bus.uart_valid & ~drop_err_c & full_q & ~pop_c;
  end

  // Next state for pointers, occupancy, status flags and the registered head.
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    head_d        = '0;
    wr_word_d     = {bus.uart_err, bus.uart_rx_data};

    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set wins over a simultaneous clear.
    overflow_d = ovf_set_c | (overflow_q & ~overflow_clr);

    // The incoming byte is the next head only when it lands where rd_ptr will point.
    if (count_d != '0) begin
      if (push_c && (wr_ptr_q == rd_ptr_d)) head_d = wr_word_d;
      else                                  head_d = mem_q[rd_ptr_d];
    end

    rd_valid_d    = (count_d != '0);
    empty_d       = (count_d == '0);
    full_d        = (count_d == CW'(DEPTH));
    almost_full_d = (count_d >= CW'(ALMOST_FULL));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      head_q        <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      rd_valid_q    <= rd_valid_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      head_q        <= head_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_word_d;
  end

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of discarded framing-error bytes.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop_err_c && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign bus.fifo_rd_data  = head_q[7:0];
  assign bus.fifo_rd_err   = head_q[8];
  assign bus.fifo_rd_valid = rd_valid_q;
  assign fifo_count        = count_q;
  assign fifo_empty        = empty_q;
  assign fifo_full         = full_q;
  assign fifo_almost_full  = almost_full_q;
  assign fifo_overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, ALMOST_FULL=12).
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic          fifo_overflow;
  logic          overflow_clr;
  logic [7:0]    err_count;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo_if bus_if ();

  uart_rx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL(12)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus_if),
    .fifo_count       (fifo_count),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_overflow    (fifo_overflow),
    .overflow_clr     (overflow_clr),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    bus_if.uart_rx_data = d;
    bus_if.uart_err     = e;
    bus_if.uart_valid   = 1'b1;
    tick();
    bus_if.uart_valid   = 1'b0;
    bus_if.uart_err     = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d);
    check({tag, " vld"}, 32'(bus_if.fifo_rd_valid), 1);
    check(tag, 32'(bus_if.fifo_rd_data), 32'(d));
    bus_if.fifo_rd_ready = 1'b1;
    tick();
    bus_if.fifo_rd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;

    reset                = 1'b0;
    overflow_clr         = 1'b0;
    bus_if.uart_rx_data  = '0;
    bus_if.uart_valid    = 1'b0;
    bus_if.uart_err      = 1'b0;
    bus_if.fifo_rd_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // reset state
    check("rst count", 32'(fifo_count), 0);
    check("rst empty", 32'(fifo_empty), 1);
    check("rst full", 32'(fifo_full), 0);
    check("rst afull", 32'(fifo_almost_full), 0);
    check("rst valid", 32'(bus_if.fifo_rd_valid), 0);
    check("rst data", 32'(bus_if.fifo_rd_data), 0);
    check("rst ovf", 32'(fifo_overflow), 0);
    check("rst errcnt", 32'(err_count), 0);

    // three bytes, ready low, then drain in order
    push(8'h34, 1'b0);
    check("t1 latency vld", 32'(bus_if.fifo_rd_valid), 1);
    check("t1 latency data", 32'(bus_if.fifo_rd_data), 32'h34);
    push(8'h55, 1'b0);
    push(8'hAF, 1'b0);
    check("t1 count", 32'(fifo_count), 3);
    tick();
    check("t1 stable head", 32'(bus_if.fifo_rd_data), 32'h34);
    pop_chk("t1 pop0", 8'h34);
    pop_chk("t1 pop1", 8'h55);
    pop_chk("t1 pop2", 8'hAF);
    check("t1 empty", 32'(fifo_empty), 1);
    check("t1 data0", 32'(bus_if.fifo_rd_data), 0);
    check("t1 vld0", 32'(bus_if.fifo_rd_valid), 0);

    // fill to full, almost_full threshold, overflow on 17th
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0);
      if (i == 10) check("t2 afull@11", 32'(fifo_almost_full), 0);
      if (i == 11) check("t2 afull@12", 32'(fifo_almost_full), 1);
      if (i == 14) check("t2 notfull@15", 32'(fifo_full), 0);
    end
    check("t2 full", 32'(fifo_full), 1);
    check("t2 count16", 32'(fifo_count), 16);
    check("t2 ovf pre", 32'(fifo_overflow), 0);
    push(8'hEE, 1'b0);
    check("t2 ovf", 32'(fifo_overflow), 1);
    check("t2 count after drop", 32'(fifo_count), 16);
    check("t2 head", 32'(bus_if.fifo_rd_data), 0);
    overflow_clr = 1'b1;
    push(8'hFE, 1'b0);
    overflow_clr = 1'b0;
    check("t2 set wins", 32'(fifo_overflow), 1);

    // full with simultaneous push and pop
    bus_if.uart_rx_data  = 8'h77;
    bus_if.uart_valid    = 1'b1;
    bus_if.fifo_rd_ready = 1'b1;
    tick();
    bus_if.uart_valid    = 1'b0;
    bus_if.fifo_rd_ready = 1'b0;
    check("t3 count16", 32'(fifo_count), 16);
    check("t3 full", 32'(fifo_full), 1);
    for (int i = 1; i < 16; i++) pop_chk("t3 pop", 8'(i));
    pop_chk("t3 last", 8'h77);
    check("t3 empty", 32'(fifo_empty), 1);
    check("t3 ovf held", 32'(fifo_overflow), 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t3 ovf clr", 32'(fifo_overflow), 0);

    // streaming writes and reads across several pointer wraps
    bus_if.fifo_rd_ready = 1'b1;
    for (int c = 0; c < 37; c++) begin
      bus_if.uart_valid   = (c < 36);
      bus_if.uart_rx_data = 8'(32'hA0 + c);
      if (bus_if.fifo_rd_valid) begin
        d = q.pop_front();
        check("t4 data", 32'(bus_if.fifo_rd_data), 32'(d));
      end
      if (c < 36) q.push_back(8'(32'hA0 + c));
      tick();
      check("t4 count", 32'(fifo_count), 32'(q.size()));
      check("t4 cnt le 16", 32'(fifo_count <= CW'(16)), 1);
    end
    bus_if.uart_valid    = 1'b0;
    bus_if.fifo_rd_ready = 1'b0;
    check("t4 empty", 32'(fifo_empty), 1);

    // framing-error byte
`ifdef UART_RX_FIFO_ERR_DROP_EN
    push(8'h5A, 1'b1);
    check("t5 empty", 32'(fifo_empty), 1);
    check("t5 vld", 32'(bus_if.fifo_rd_valid), 0);
    check("t5 errcnt1", 32'(err_count), 1);
    repeat (299) push(8'h5A, 1'b1);
    check("t5 errcnt sat", 32'(err_count), 255);
    check("t5 no ovf", 32'(fifo_overflow), 0);
`else
    push(8'h5A, 1'b1);
    check("t5 vld", 32'(bus_if.fifo_rd_valid), 1);
    check("t5 err tag", 32'(bus_if.fifo_rd_err), 1);
    check("t5 errcnt tied", 32'(err_count), 0);
    pop_chk("t5 pop", 8'h5A);
    check("t5 err cleared", 32'(bus_if.fifo_rd_err), 0);
`endif

    // reset while holding data and a set overflow flag
    for (int i = 0; i < 17; i++) push(8'(32'hC0 + i), 1'b0);
    check("t6 pre ovf", 32'(fifo_overflow), 1);
    check("t6 pre count", 32'(fifo_count), 16);
    reset = 1'b0;
    tick();
    check("t6 count", 32'(fifo_count), 0);
    check("t6 vld", 32'(bus_if.fifo_rd_valid), 0);
    check("t6 ovf", 32'(fifo_overflow), 0);
    check("t6 empty", 32'(fifo_empty), 1);
    reset = 1'b1;
    tick();
    push(8'h12, 1'b0);
    check("t6 count1", 32'(fifo_count), 1);
    pop_chk("t6 readback", 8'h12);
    check("t6 empty end", 32'(fifo_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
